// File: rtl/param_data_memory_pkg.sv
// Shared definitions for the parametrised data memory.
//   - request direction encoding (MEMORY_READ / MEMORY_WRITE)
//   - controller state encoding (MEM_ST_CLEAR / MEM_ST_READY)
//   - default geometry keyed to the CPU word and memory size
package param_data_memory_pkg;

  localparam int WORD_VEC_W    = 32;
  localparam int MEMORY_LENGTH = 256;

  localparam int DEF_DATA_W = WORD_VEC_W;
  localparam int DEF_DEPTH  = MEMORY_LENGTH;
  localparam int DEF_ADDR_W = 8;

  localparam logic MEMORY_READ  = 1'b0;
  localparam logic MEMORY_WRITE = 1'b1;

  typedef enum logic {
    MEM_ST_CLEAR = 1'b0,
    MEM_ST_READY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_bytelane_ram.sv
// Single-port RAM with per-byte write enables and a read-first registered
// output, written so it maps onto block RAM.
// Ports:
//   clk   - clock, rising edge
//   en    - read enable; rdata captures mem[addr] (old contents) when high
//   we    - one write enable per byte lane, independent of en
//   addr  - word address (must be < DEPTH whenever en or we is active)
//   wdata - write data
//   rdata - registered read data, holds when en is low
module mem_bytelane_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  // Read and lane writes share one process so the read returns the
  // pre-write word (read-first).
  always_ff @(posedge clk) begin
    if (en) rdata <= mem[addr];
    for (int i = 0; i < STRB_W; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/param_data_memory.sv
// Parametrised single-port data memory with byte strobes, 1-cycle registered
// read, write-through echo, out-of-range error response and a hardware
// zero-fill sequencer that runs after reset and on clear_req.
// Ports:
//   clk, reset (async, active high)
//   clear_req            - pulse: zero-fill the whole array
//   req_valid/req_ready  - request handshake
//   req_write, req_addr, req_wdata, req_strb - request fields
//   rsp_valid, rsp_data, rsp_err - response, one cycle after acceptance
//   busy                 - clear sequence in progress
//
// state        | meaning
// MEM_ST_CLEAR | writing zero to mem[clr_ptr], requests refused
// MEM_ST_READY | accepting one request per cycle
module param_data_memory
  import param_data_memory_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_strb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  mem_state_t        state, state_nxt;
  logic [PTR_W-1:0]  clr_ptr;
  logic              accept, in_range;

  logic              ram_en;
  logic [STRB_W-1:0] ram_we;
  logic [PTR_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic              rsp_valid_q, rsp_err_q, rsp_wr_q;
  logic [DATA_W-1:0] wdata_q, hold_q, merged, rsp_cur;
  logic [STRB_W-1:0] strb_q;

  assign req_ready = (state == MEM_ST_READY);
  assign busy      = (state == MEM_ST_CLEAR);
  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, req_addr} < DEPTH_L;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MEM_ST_CLEAR;
    else       state <= state_nxt;
  end

  // The clear sequencer owns the RAM port while clearing; a request taken on
  // the same edge as clear_req uses the port first, clearing starts after.
  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = PTR_W'(req_addr);
    ram_wdata = req_wdata;
    unique case (state)
      MEM_ST_CLEAR: begin
        ram_we    = '1;
        ram_addr  = clr_ptr;
        ram_wdata = '0;
        if (!clear_req && clr_ptr == LAST_PTR) state_nxt = MEM_ST_READY;
      end
      MEM_ST_READY: begin
        if (accept && in_range) begin
          ram_en = 1'b1;
          if (req_write == MEMORY_WRITE) ram_we = req_strb;
        end
        if (clear_req) state_nxt = MEM_ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      clr_ptr <= '0;
    else if (clear_req)             clr_ptr <= '0;
    else if (state == MEM_ST_CLEAR) clr_ptr <= clr_ptr + PTR_W'(1);
  end

  mem_bytelane_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PTR_W),
    .STRB_W (STRB_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_wr_q    <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      hold_q      <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_err_q <= !in_range;
        rsp_wr_q  <= (req_write != MEMORY_READ);
        wdata_q   <= req_wdata;
        strb_q    <= req_strb;
      end
      if (rsp_valid_q) hold_q <= rsp_cur;
    end
  end

  // Write echo: the RAM returned the old word (read-first); overlay the
  // strobed lanes of the registered write data.
  always_comb begin
    merged = ram_rdata;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
    if (rsp_err_q)     rsp_cur = '0;
    else if (rsp_wr_q) rsp_cur = merged;
    else               rsp_cur = ram_rdata;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q && rsp_err_q;
  assign rsp_data  = rsp_valid_q ? rsp_cur : hold_q;

endmodule

// File: tb/tb_param_data_memory.sv
// Bench for param_data_memory: two instances (DEPTH 256 and DEPTH 200) share
// the same stimulus; a byte-level array model predicts each response, and a
// per-cycle monitor checks response timing, data, error flag and hold value.
module tb_param_data_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear_req, req_valid, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;

  logic        ready_a, valid_a, err_a, busy_a;
  logic [31:0] data_a;
  logic        ready_b, valid_b, err_b, busy_b;
  logic [31:0] data_b;

  param_data_memory dut_a (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .req_valid(req_valid), .req_ready(ready_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(valid_a), .rsp_data(data_a), .rsp_err(err_a), .busy(busy_a)
  );

  param_data_memory #(.DATA_W(32), .DEPTH(200), .ADDR_W(8)) dut_b (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .req_valid(req_valid), .req_ready(ready_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(valid_b), .rsp_data(data_b), .rsp_err(err_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q_a[$], q_b[$];
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [200];
  logic [31:0] last_a = '0, last_b = '0;
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void model_zero();
    foreach (mem_a[i]) mem_a[i] = '0;
    foreach (mem_b[i]) mem_b[i] = '0;
  endfunction

  function automatic logic [31:0] lane_merge(logic [31:0] old, logic [31:0] wd, logic [3:0] st);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (st[i]) m = m | (32'hFF << (8 * i));
    return (old & ~m) | (wd & m);
  endfunction

  // Called at a falling edge; the request is taken on the next rising edge.
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic clr);
    exp_t e;
    logic [31:0] nw;
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wd;   req_strb  = st; clear_req = clr;
    e.due = cyc + 1;
    nw = lane_merge(mem_a[addr], wd, st);
    e.err  = 1'b0;
    e.data = wr ? nw : mem_a[addr];
    if (wr) mem_a[addr] = nw;
    q_a.push_back(e);
    if (addr >= 8'd200) begin
      e.err = 1'b1; e.data = '0;
    end else begin
      nw = lane_merge(mem_b[addr], wd, st);
      e.err  = 1'b0;
      e.data = wr ? nw : mem_b[addr];
      if (wr) mem_b[addr] = nw;
    end
    q_b.push_back(e);
    if (clr) model_zero();
    @(negedge clk);
    req_valid = 1'b0; clear_req = 1'b0;
  endtask

  task automatic mon(input int w, input logic v, input logic [31:0] d, input logic e);
    exp_t x;
    logic due;
    string p = (w == 0) ? "a" : "b";
    if (w == 0) due = (q_a.size() > 0) && (q_a[0].due == cyc);
    else        due = (q_b.size() > 0) && (q_b[0].due == cyc);
    check({p, " rsp_valid"}, 32'(v), 32'(due));
    if (due) begin
      x = (w == 0) ? q_a.pop_front() : q_b.pop_front();
      check({p, " rsp_data"}, d, x.data);
      check({p, " rsp_err"}, 32'(e), 32'(x.err));
      if (w == 0) last_a = x.data; else last_b = x.data;
    end else begin
      check({p, " idle rsp_err"}, 32'(e), 32'd0);
      check({p, " idle rsp_data hold"}, d, (w == 0) ? last_a : last_b);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, valid_a, data_a, err_a);
      mon(1, valid_b, data_b, err_b);
    end
  end

  // Entered at a falling edge just after reset release or a clear accept.
  task automatic count_busy(input string tag);
    int ca = 0, cb = 0, fa = 0, fb = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (busy_a) ca++; else if (fa == 0 && ready_a) fa = i + 1;
      if (busy_b) cb++; else if (fb == 0 && ready_b) fb = i + 1;
      @(negedge clk);
    end
    check({tag, " a busy cycles"}, ca, 256);
    check({tag, " b busy cycles"}, cb, 200);
    check({tag, " a first ready cycle"}, fa, 257);
    check({tag, " b first ready cycle"}, fb, 201);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear_req = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_strb = '0;
    model_zero();
    repeat (3) @(negedge clk);
    check("reset a busy", 32'(busy_a), 32'd1);
    check("reset a ready", 32'(ready_a), 32'd0);
    check("reset a rsp_valid", 32'(valid_a), 32'd0);
    check("reset a rsp_data", data_a, 32'd0);
    check("reset a rsp_err", 32'(err_a), 32'd0);
    check("reset b busy", 32'(busy_b), 32'd1);
    check("reset b ready", 32'(ready_b), 32'd0);
    check("reset b rsp_valid", 32'(valid_b), 32'd0);
    reset = 1'b0;
    count_busy("post-reset");

    issue(1'b0, 8'h00, '0, 4'h0, 1'b0);
    issue(1'b0, 8'hFF, '0, 4'h0, 1'b0);
    @(negedge clk);

    issue(1'b1, 8'd5, 32'hDEADBEEF, 4'b1111, 1'b0);
    issue(1'b1, 8'd5, 32'h000000AA, 4'b0001, 1'b0);
    issue(1'b0, 8'd5, '0, 4'h0, 1'b0);
    @(negedge clk);

    issue(1'b1, 8'd3, 32'h00000011, 4'b1111, 1'b0);
    issue(1'b0, 8'd3, '0, 4'h0, 1'b0);
    @(negedge clk);

    issue(1'b1, 8'd50, 32'h5A5A5A5A, 4'b1111, 1'b0);
    issue(1'b0, 8'd210, '0, 4'h0, 1'b0);
    issue(1'b1, 8'd250, 32'hCAFEF00D, 4'b1111, 1'b0);
    issue(1'b0, 8'd50, '0, 4'h0, 1'b0);
    issue(1'b1, 8'd9, 32'h12345678, 4'b0000, 1'b0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      else issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end
    @(negedge clk);

    issue(1'b1, 8'd7, 32'h00000055, 4'b1111, 1'b1);
    count_busy("clear_req");
    issue(1'b0, 8'd7, '0, 4'h0, 1'b0);
    issue(1'b0, 8'd5, '0, 4'h0, 1'b0);
    @(negedge clk);

    // Reset lands between edges while a read taken with clear_req is in flight.
    issue(1'b1, 8'd20, 32'hA5A5A5A5, 4'b1111, 1'b0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd20; clear_req = 1'b1;
    @(posedge clk);
    #2;
    check("in-flight a rsp_valid", 32'(valid_a), 32'd1);
    req_valid = 1'b0; clear_req = 1'b0;
    reset = 1'b1;
    q_a.delete(); q_b.delete();
    last_a = '0; last_b = '0;
    model_zero();
    #1;
    check("async reset a rsp_valid", 32'(valid_a), 32'd0);
    check("async reset b rsp_valid", 32'(valid_b), 32'd0);
    check("async reset a busy", 32'(busy_a), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    count_busy("mid-clear reset");
    issue(1'b0, 8'd20, '0, 4'h0, 1'b0);
    issue(1'b0, 8'd5, '0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);

    check("a responses outstanding", q_a.size(), 0);
    check("b responses outstanding", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
